// File: rtl/note_sequencer.sv
// Purpose : queues mouse-click note events (4-deep FIFO) and plays each one for NOTE_CYCLES,
//           then stays silent for GAP_CYCLES before the next note.
// Latency : a click on an idle, empty sequencer enables the tone 3 edges after outc is first sampled high.
// Backpressure: none upstream; a click arriving at a full queue is dropped and flagged on overflow.
// Ports   : CLOCK_50 clock, KEY async active-low reset, note_num/outc click input, flush sync clear;
//           tone_num/tone_en to the tone generator, busy, q_count occupancy, overflow drop pulse.
// Option  : define NOTE_SEQ_DEDUP_EN to drop a click that repeats the last queued note while the
//           queue is non-empty.
module note_sequencer #(
  parameter int NOTE_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic [5:0] note_num,
  input  logic       outc,
  input  logic       flush,
  output logic [5:0] tone_num,
  output logic       tone_en,
  output logic       busy,
  output logic [2:0] q_count,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  localparam logic [24:0] NOTE_LOAD = 25'(NOTE_CYCLES - 1);
  localparam logic [24:0] GAP_LOAD  = 25'(GAP_CYCLES - 1);

  // click edge detect and one-cycle event staging
  logic       outc_q;
  logic       evt_vld_q, evt_vld_d;
  logic [5:0] evt_note_q;

  // FIFO
  logic [5:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       push, pop, dup;
  logic       overflow_q, overflow_d;

  // playback FSM
  state_e      state_q, state_d;
  logic [24:0] cnt_q, cnt_d;
  logic        tone_en_q, tone_en_d;
  logic [5:0]  tone_num_q, tone_num_d;

  // A rising click edge with a real note is staged for one cycle before entering the FIFO;
  // that staging stage is what sets the 3-edge click-to-tone latency.
  assign evt_vld_d = outc & ~outc_q & (note_num != 6'd0) & ~flush;

`ifdef NOTE_SEQ_DEDUP_EN
  logic [5:0] last_note_q;
  assign dup = evt_vld_q & (count_q != 3'd0) & (evt_note_q == last_note_q);
`else
  assign dup = 1'b0;
`endif

  // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside a pop.
  assign push       = evt_vld_q & ~dup & ~flush & ((count_q != 3'd4) | pop);
  assign overflow_d = evt_vld_q & ~dup & ~flush & (count_q == 3'd4) & ~pop;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = 3'd0;
    end else begin
      count_d = count_q + 3'(push) - 3'(pop);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tone_en_d  = tone_en_q;
    tone_num_d = tone_num_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        tone_en_d  = 1'b0;
        tone_num_d = 6'd0;
        if (count_q != 3'd0) begin
          pop        = 1'b1;
          state_d    = PLAY;
          cnt_d      = NOTE_LOAD;
          tone_en_d  = 1'b1;
          tone_num_d = mem_q[rd_ptr_q];
        end
      end
      PLAY: begin
        if (cnt_q == 25'd0) begin
          state_d    = GAP;
          cnt_d      = GAP_LOAD;
          tone_en_d  = 1'b0;
          tone_num_d = 6'd0;
        end else begin
          cnt_d = cnt_q - 25'd1;
        end
      end
      GAP: begin
        if (cnt_q == 25'd0) begin
          if (count_q != 3'd0) begin
            pop        = 1'b1;
            state_d    = PLAY;
            cnt_d      = NOTE_LOAD;
            tone_en_d  = 1'b1;
            tone_num_d = mem_q[rd_ptr_q];
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 25'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = 25'd0;
        tone_en_d  = 1'b0;
        tone_num_d = 6'd0;
      end
    endcase
    // flush overrides every other action, including a pop this cycle
    if (flush) begin
      state_d    = IDLE;
      cnt_d      = 25'd0;
      tone_en_d  = 1'b0;
      tone_num_d = 6'd0;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      outc_q     <= 1'b0;
      evt_vld_q  <= 1'b0;
      evt_note_q <= 6'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= 25'd0;
      tone_en_q  <= 1'b0;
      tone_num_q <= 6'd0;
    end else begin
      outc_q     <= outc;
      evt_vld_q  <= evt_vld_d;
      evt_note_q <= note_num;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tone_en_q  <= tone_en_d;
      tone_num_q <= tone_num_d;
      if (flush) begin
        wr_ptr_q <= 2'd0;
        rd_ptr_q <= 2'd0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      end
    end
  end

`ifdef NOTE_SEQ_DEDUP_EN
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      last_note_q <= 6'd0;
    end else if (push) begin
      last_note_q <= evt_note_q;
    end
  end
`endif

  // storage needs no reset: entries are only read below the occupancy count
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= evt_note_q;
  end

  assign tone_num = tone_num_q;
  assign tone_en  = tone_en_q;
  assign q_count  = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) | (count_q != 3'd0);

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  localparam int NOTE = 64;
  localparam int GAPC = 6;

  logic       clk = 1'b0;
  logic       key = 1'b0;
  logic [5:0] note_num = 6'd0;
  logic       outc = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] tone_num;
  logic       tone_en;
  logic       busy;
  logic [2:0] q_count;
  logic       overflow;

  note_sequencer #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(GAPC)) dut (
    .CLOCK_50(clk), .KEY(key), .note_num(note_num), .outc(outc), .flush(flush),
    .tone_num(tone_num), .tone_en(tone_en), .busy(busy), .q_count(q_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: notes expected to sound, in order
  logic [5:0] exp_q[$];
  logic       mon_en = 1'b0;
  int         ovf_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // monitor: every rising tone_en pops the scoreboard; note and gap lengths are measured
  logic prev_en = 1'b0;
  int   high_len = 0;
  int   gap_len = 0;
  logic in_gap = 1'b0;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_en  = tone_en;
      high_len = 0;
      in_gap   = 1'b0;
    end else begin
      if (overflow) ovf_cnt++;
      if (tone_en && !prev_en) begin
        if (in_gap) check("gap_len", gap_len, GAPC);
        in_gap = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_note: got 0x%0h, expected no note at %0t", tone_num, $time);
        end else begin
          check("tone_num", int'(tone_num), int'(exp_q.pop_front()));
        end
        high_len = 1;
      end else if (tone_en) begin
        high_len++;
      end else if (prev_en) begin
        check("note_len", high_len, NOTE);
        check("silent_num", int'(tone_num), 0);
        in_gap  = 1'b1;
        gap_len = 1;
      end else if (in_gap) begin
        if (!busy) begin
          check("last_gap_len", gap_len, GAPC);
          in_gap = 1'b0;
        end else begin
          gap_len++;
        end
      end
      prev_en = tone_en;
    end
  end

  task automatic click(input logic [5:0] n);
    @(negedge clk);
    note_num = n;
    outc = 1'b1;
    @(negedge clk);
    outc = 1'b0;
  endtask

  task automatic wait_tone();
    int k = 0;
    while (!tone_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("tone_started", int'(tone_en), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  // click on an idle sequencer: tone must appear on exactly the 3rd edge
  task automatic click_latency(input logic [5:0] n);
    logic [2:0] seen;
    @(negedge clk);
    exp_q.push_back(n);
    note_num = n;
    outc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 seen[k] = tone_en;
    end
    check("lat_edge1", int'(seen[0]), 0);
    check("lat_edge2", int'(seen[1]), 0);
    check("lat_edge3", int'(seen[2]), 1);
    @(negedge clk);
    outc = 1'b0;
  endtask

  // Burst model: the first click sounds at once, later clicks fill a 4-deep list while
  // the first note plays; anything beyond that is an overflow.
  logic [5:0] bnotes[8];
  task automatic burst(input int n);
    logic [5:0] pend[$];
    int exp_ovf = 0;
    ovf_cnt = 0;
    exp_q.push_back(bnotes[0]);
    click(bnotes[0]);
    wait_tone();
    for (int i = 1; i < n; i++) begin
      logic drop_dup;
      drop_dup = 1'b0;
`ifdef NOTE_SEQ_DEDUP_EN
      if (pend.size() != 0 && pend[pend.size()-1] == bnotes[i]) drop_dup = 1'b1;
`endif
      if (!drop_dup) begin
        if (pend.size() < 4) pend.push_back(bnotes[i]);
        else exp_ovf++;
      end
      click(bnotes[i]);
    end
    repeat (3) @(negedge clk);
    check("burst_q_count", int'(q_count), pend.size());
    check("burst_overflow", ovf_cnt, exp_ovf);
    foreach (pend[i]) exp_q.push_back(pend[i]);
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tone_en", int'(tone_en), 0);
    check("rst_tone_num", int'(tone_num), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_q_count", int'(q_count), 0);
    check("rst_overflow", int'(overflow), 0);
    key = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // single note: latency, duration and gap
    click_latency(6'h16);
    wait_idle();
    check("single_q_count", int'(q_count), 0);

    // six clicks during one note: four queued, one overflow
    bnotes[0] = 6'h16; bnotes[1] = 6'h19; bnotes[2] = 6'h1D;
    bnotes[3] = 6'h20; bnotes[4] = 6'h16; bnotes[5] = 6'h19;
    burst(6);

    // holding outc produces one event only
    @(negedge clk);
    exp_q.push_back(6'h20);
    note_num = 6'h20;
    outc = 1'b1;
    repeat (1000) @(negedge clk);
    outc = 1'b0;
    wait_idle();

    // a click with no note queues nothing
    click(6'h00);
    repeat (4) @(negedge clk);
    check("zero_note_q_count", int'(q_count), 0);
    check("zero_note_busy", int'(busy), 0);

    // repeated note clicks (dedup-aware model)
    bnotes[0] = 6'h16; bnotes[1] = 6'h19; bnotes[2] = 6'h19; bnotes[3] = 6'h1D;
    burst(4);

    // flush mid-PLAY with three notes queued
    exp_q.push_back(6'h01);
    click(6'h01);
    wait_tone();
    click(6'h02); click(6'h03); click(6'h04);
    repeat (3) @(negedge clk);
    check("preflush_q_count", int'(q_count), 3);
    mon_en = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_tone_en", int'(tone_en), 0);
    check("flush_tone_num", int'(tone_num), 0);
    check("flush_q_count", int'(q_count), 0);
    check("flush_busy", int'(busy), 0);
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("postflush_busy", int'(busy), 0);
    mon_en = 1'b1;

    // asynchronous reset mid-PLAY
    exp_q.push_back(6'h05);
    click(6'h05);
    wait_tone();
    click(6'h06);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    @(posedge clk);
    #3 key = 1'b0;
    #1;
    check("arst_tone_en", int'(tone_en), 0);
    check("arst_q_count", int'(q_count), 0);
    check("arst_busy", int'(busy), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    key = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    click_latency(6'h1D);
    wait_idle();

    // randomized bursts, small note alphabet half the time to provoke repeats
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 0) bnotes[i] = 6'($urandom_range(1, 3));
        else bnotes[i] = 6'($urandom_range(1, 63));
      end
      burst(n);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
